weighted_arbitration_unit: RTL and testbench
============================================

Name: weighted_arbitration_unit

Overview:
- Parametrised successor to the single-cycle round-robin arbiter.
- Grants exclusive access to a shared resource, one client at a time, in the same cycle the request is seen.
- Each grantee keeps the grant for up to a per-client, run-time-programmable weight of consecutive cycles (burst quota) before rotation.
- Adds optional hold-lock, an encoded grant index and a remaining-credit status output; used wherever masters share memory or bus ports with unequal bandwidth needs.

Parameters:
- NUM_CLIENTS, 8, number of requesters; must be >= 1.
- WEIGHT_WIDTH, 4, bits per client weight; maximum burst is 2^WEIGHT_WIDTH-1 cycles.
- CAN_HOLD, 0, when 1 the hold input freezes the current grant and its credit.
- SEL_W (localparam), NUM_CLIENTS>1 ? clog2(NUM_CLIENTS) : 1, index width.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- requests  in  NUM_CLIENTS  bit i high = client i requests access.
- weights  in  NUM_CLIENTS*WEIGHT_WIDTH  client i weight at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- hold  in  1  keep current owner granted while high; ignored if CAN_HOLD=0.
- grants  out  NUM_CLIENTS  one-hot or zero, combinational.
- grant_valid  out  1  OR of grants.
- grant_idx  out  SEL_W  index of granted client; 0 when grant_valid=0.
- credit  out  WEIGHT_WIDTH  registered remaining burst cycles of the current owner after this cycle.

Behaviour:
- State registers:
  - owner (SEL_W): current owner index.
  - owner_valid (1): an owner is held over from the previous cycle.
  - last_selected (SEL_W): round-robin pointer.
  - credit (WEIGHT_WIDTH): remaining burst cycles.
- Reset (async, rst_n low):
  - owner=0, owner_valid=0, last_selected=NUM_CLIENTS-1 (client 0 has first priority), credit=0.
  - grants, grant_valid and grant_idx are forced to 0 while rst_n is low.
- Effective weight: eff_w[i] = (weights[i]==0) ? 1 : weights[i]. A weight of 0 behaves as 1.
- Same-cycle grant selection (combinational):
  - Continue: owner_valid && requests[owner] && (credit>0 || (CAN_HOLD && hold)). Grant the owner.
  - Otherwise, rotate: scan clients last_selected+1, +2, … wrapping modulo NUM_CLIENTS, ending at last_selected itself. Grant the first requester found.
  - If no client requests, grants=0.
- Register update on posedge clk:
  - New pick p: owner=p, last_selected=p, owner_valid=1, credit=eff_w[p]-1. Weights are sampled only here; weight changes mid-burst take effect on the next pick.
  - Continue with hold active (CAN_HOLD=1): all state unchanged.
  - Continue without hold: credit=credit-1.
  - No grant: owner_valid=0, credit=0; last_selected unchanged.
- Burst length: a client with eff_w=W and a continuous request holds the grant for exactly W consecutive cycles. It then loses priority to other requesters.
- If that client is the only requester, rotation re-picks it and reloads credit, so the grant is continuous with no bubble.
- Owner drops its request mid-burst: in that same cycle, rotation proceeds from the owner's index and the remaining credit is discarded.
- Hold:
  - While held, credit does not decrement and the owner keeps the grant as long as it requests.
  - Hold with the owner not requesting is ignored and rotation proceeds.
  - Hold with owner_valid=0 has no effect.
- NUM_CLIENTS=1: client 0 is granted whenever it requests; credit still counts and reloads.
- Latency: a grant appears in the same cycle as the request, with no registered delay.
- Reset mid-burst: the grant drops immediately. After release, arbitration restarts with client 0 first.
- Invariant: grants is one-hot or zero in every cycle; assert this in the bench.

Test Plan:
- N=4, W=3, weights all 1, requests=4'b0111 held for 6 cycles -> grant_idx 0,1,2,0,1,2 (plain round-robin).
- weights={1,1,2,3} (clients 3..0), requests=4'b0011 for 10 cycles -> client0 for 3 cycles, client1 for 2, client0 for 3, client1 for 2. grant_valid stays high throughout.
- Only client 2 requests, weight 2, for 5 cycles -> grants=4'b0100 every cycle. credit sequence: 1,0,1,0,1.
- Client 1 (weight 5) granted, drops its request on its 2nd cycle while client 3 requests -> client 3 is granted in that same cycle; client 1's credit is discarded.
- CAN_HOLD=1: client 0 (weight 1) granted with hold=1 for 4 cycles while client 1 requests -> client 0 is granted all 4 cycles. Client 1 is granted in the first cycle after hold falls.
- Assert rst_n low mid-burst of client 2 -> grants=0 immediately. After release with requests=4'b1111 -> client 0 is granted first.

Source files
------------

// File: rtl/weighted_arbitration_unit.sv
// Weighted round-robin arbiter. The grant is combinational in the request
// cycle. Each owner keeps the grant for up to its programmed burst weight
// before the grant rotates. Optional hold freezes the owner and its credit.
module weighted_arbitration_unit #(
   parameter int NUM_CLIENTS  = 8,
   parameter int WEIGHT_WIDTH = 4,
   parameter bit CAN_HOLD     = 1'b0,
   localparam int SEL_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_CLIENTS-1:0]               requests,
   input  logic [NUM_CLIENTS*WEIGHT_WIDTH-1:0]  weights,
   input  logic                                 hold,
   output logic [NUM_CLIENTS-1:0]               grants,
   output logic                                 grant_valid,
   output logic [SEL_W-1:0]                     grant_idx,
   output logic [WEIGHT_WIDTH-1:0]              credit
);

   logic [SEL_W-1:0]        owner;
   logic [SEL_W-1:0]        last_selected;
   logic                    owner_valid;
   logic [WEIGHT_WIDTH-1:0] credit_q;

   logic                    hold_en;
   logic                    owner_req;
   logic                    keep;
   logic                    found;
   logic [SEL_W-1:0]        pick;
   logic [WEIGHT_WIDTH-1:0] pick_w;
   logic [SEL_W-1:0]        sel_idx;

   assign hold_en = (CAN_HOLD != 1'b0) && hold;
   assign credit  = credit_q;

   // Does the held-over owner still request? (constant-index scan keeps selects in range)
   always_comb begin
      owner_req = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (SEL_W'(i) == owner) owner_req = requests[i];
      end
   end

   // Owner continues while it requests and has credit left, or is held
   assign keep = owner_valid && owner_req && ((credit_q != '0) || hold_en);

   // Rotation: first requester after last_selected, wrapping, ending on last_selected
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int k = 1; k <= NUM_CLIENTS; k++) begin
         idx = int'(last_selected) + k;
         if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && (i == idx) && requests[i]) begin
               found = 1'b1;
               pick  = SEL_W'(i);
            end
         end
      end
   end

   // Effective weight of the rotation pick; a programmed 0 behaves as 1
   always_comb begin
      pick_w = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (SEL_W'(i) == pick) pick_w = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
      if (pick_w == '0) pick_w = WEIGHT_WIDTH'(1);
   end

   // Grant outputs, forced low while reset is asserted
   always_comb begin
      grants    = '0;
      grant_idx = '0;
      sel_idx   = keep ? owner : pick;
      if (rst_n && (keep || found)) begin
         grant_idx = sel_idx;
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (SEL_W'(i) == sel_idx) grants[i] = 1'b1;
         end
      end
   end

   assign grant_valid = |grants;

   // Owner, rotation pointer and burst credit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner         <= '0;
         owner_valid   <= 1'b0;
         last_selected <= SEL_W'(NUM_CLIENTS - 1);
         credit_q      <= '0;
      end else if (keep) begin
         if (!hold_en) credit_q <= credit_q - WEIGHT_WIDTH'(1);
      end else if (found) begin
         owner         <= pick;
         last_selected <= pick;
         owner_valid   <= 1'b1;
         credit_q      <= pick_w - WEIGHT_WIDTH'(1);
      end else begin
         owner_valid   <= 1'b0;
         credit_q      <= '0;
      end
   end

endmodule

// File: tb/tb_weighted_arbitration_unit.sv
// Bench for the weighted arbiter: a burst-usage model checked on every
// falling edge, plus directed sequences with hand-computed grants/credits.
module tb_weighted_arbitration_unit;

   localparam int N  = 4;
   localparam int WW = 3;
   localparam bit CH = 1'b1;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b1;
   logic [N-1:0]  requests = '0;
   logic [N*WW-1:0] weights = '0;
   logic          hold     = 1'b0;
   logic [N-1:0]  grants;
   logic          grant_valid;
   logic [1:0]    grant_idx;
   logic [WW-1:0] credit;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   // model: who owns, how many cycles of the burst are used, burst length
   int m_owner, m_ptr, m_used, m_wpick;
   bit m_valid;

   weighted_arbitration_unit #(
      .NUM_CLIENTS(N), .WEIGHT_WIDTH(WW), .CAN_HOLD(CH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .requests(requests), .weights(weights),
      .hold(hold), .grants(grants), .grant_valid(grant_valid),
      .grant_idx(grant_idx), .credit(credit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic int eff_w(input int i);
      logic [N*WW-1:0] sh;
      int w;
      sh = weights >> (i * WW);
      w  = int'(sh[WW-1:0]);
      return (w == 0) ? 1 : w;
   endfunction

   task automatic model_reset();
      m_owner = 0; m_valid = 1'b0; m_ptr = N - 1; m_used = 0; m_wpick = 1;
   endtask

   // Model compare and advance, once per cycle on the falling edge
   always @(negedge clk) begin
      int  exp_idx, c, ecr;
      int  onehot_exp;
      logic [1:0] osel, csel;
      bit  cont;
      if (chk_en) begin
         assert ($onehot0(grants)) else $error("FAIL onehot0 grants=%b", grants);
         if (!rst_n) begin
            model_reset();
            chk("rst_grants", int'(grants), 0);
            chk("rst_valid", int'(grant_valid), 0);
            chk("rst_credit", int'(credit), 0);
         end else begin
            ecr = m_valid ? (m_wpick - m_used) : 0;
            chk("model_credit", int'(credit), ecr);
            osel = m_owner[1:0];
            cont = m_valid && requests[osel] && ((m_used < m_wpick) || (CH && hold));
            exp_idx = -1;
            if (cont) exp_idx = m_owner;
            else begin
               for (int k = 1; k <= N; k++) begin
                  c = (m_ptr + k) % N;
                  csel = c[1:0];
                  if (exp_idx < 0 && requests[csel]) exp_idx = c;
               end
            end
            onehot_exp = (exp_idx < 0) ? 0 : (1 << exp_idx);
            chk("model_grants", int'(grants), onehot_exp);
            chk("model_valid", int'(grant_valid), (exp_idx >= 0) ? 1 : 0);
            chk("model_idx", int'(grant_idx), (exp_idx < 0) ? 0 : exp_idx);
            if (cont) begin
               if (!(CH && hold)) m_used++;
            end else if (exp_idx >= 0) begin
               m_owner = exp_idx; m_ptr = exp_idx; m_valid = 1'b1;
               m_wpick = eff_w(exp_idx); m_used = 1;
            end else begin
               m_valid = 1'b0; m_used = 0;
            end
         end
      end
   end

   // Called at posedge+1: drive, check grant before the falling edge, then credit after the next edge
   task automatic step(input logic [N-1:0] r, input logic h, input int exp_idx, input int exp_cr);
      requests = r;
      hold     = h;
      #3;
      if (exp_idx < 0) chk("lit_valid", int'(grant_valid), 0);
      else chk("lit_idx", int'(grant_idx), exp_idx);
      @(posedge clk);
      #1;
      chk("lit_credit", int'(credit), exp_cr);
   endtask

   task automatic do_reset(input logic [N*WW-1:0] w);
      @(posedge clk);
      #1;
      rst_n = 1'b0; requests = '0; hold = 1'b0; weights = w;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1;
      rst_n  = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("init_grants", int'(grants), 0);
      chk("init_credit", int'(credit), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // plain round robin, all weights 1 (client 1 programmed 0, acts as 1)
      do_reset({3'd1, 3'd1, 3'd0, 3'd1});
      step(4'b0111, 1'b0, 0, 0);
      step(4'b0111, 1'b0, 1, 0);
      step(4'b0111, 1'b0, 2, 0);
      step(4'b0111, 1'b0, 0, 0);
      step(4'b0111, 1'b0, 1, 0);
      step(4'b0111, 1'b0, 2, 0);
      step(4'b0000, 1'b0, -1, 0);

      // weights client0=3, client1=2
      do_reset({3'd1, 3'd1, 3'd2, 3'd3});
      step(4'b0011, 1'b0, 0, 2);
      step(4'b0011, 1'b0, 0, 1);
      step(4'b0011, 1'b0, 0, 0);
      step(4'b0011, 1'b0, 1, 1);
      step(4'b0011, 1'b0, 1, 0);
      step(4'b0011, 1'b0, 0, 2);
      step(4'b0011, 1'b0, 0, 1);
      step(4'b0011, 1'b0, 0, 0);
      step(4'b0011, 1'b0, 1, 1);
      step(4'b0011, 1'b0, 1, 0);

      // single requester re-picked with no bubble
      do_reset({3'd1, 3'd2, 3'd1, 3'd1});
      step(4'b0100, 1'b0, 2, 1);
      step(4'b0100, 1'b0, 2, 0);
      step(4'b0100, 1'b0, 2, 1);
      step(4'b0100, 1'b0, 2, 0);
      step(4'b0100, 1'b0, 2, 1);

      // owner drops mid-burst, remaining credit discarded
      do_reset({3'd2, 3'd1, 3'd5, 3'd1});
      step(4'b0010, 1'b0, 1, 4);
      step(4'b1000, 1'b0, 3, 1);
      step(4'b1000, 1'b0, 3, 0);

      // hold freezes owner 0 past its weight-1 burst
      do_reset({3'd1, 3'd1, 3'd1, 3'd1});
      step(4'b0011, 1'b1, 0, 0);
      step(4'b0011, 1'b1, 0, 0);
      step(4'b0011, 1'b1, 0, 0);
      step(4'b0011, 1'b1, 0, 0);
      step(4'b0011, 1'b0, 1, 0);

      // reset mid-burst of client 2
      do_reset({3'd1, 3'd5, 3'd1, 3'd1});
      step(4'b0100, 1'b0, 2, 4);
      step(4'b0100, 1'b0, 2, 3);
      rst_n = 1'b0;
      #1;
      chk("midrst_grants", int'(grants), 0);
      chk("midrst_valid", int'(grant_valid), 0);
      chk("midrst_idx", int'(grant_idx), 0);
      chk("midrst_credit", int'(credit), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4'b1111, 1'b0, 0, 0);
      step(4'b1111, 1'b0, 1, 0);
      step(4'b1111, 1'b0, 2, 4);

      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
